// File: rtl/key_debounce.sv
// key_debounce: synchroniser and per-key debouncer for three active-low buttons.
// Define KEY_REPEAT_EN to add auto-repeat pulses while a key stays held.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CNT  = 20,
    parameter int unsigned CNT_W         = 30,
    parameter int unsigned REPEAT_DELAY  = 1000,
    parameter int unsigned REPEAT_PERIOD = 200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] key_n,
    output logic [2:0] key_status,
    output logic [2:0] key_level
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPT_NEXT  =
        CNT_W'(REPEAT_DELAY + REPEAT_PERIOD);
`else
    // Repeat timing is accepted for interface compatibility only.
    if (REPEAT_DELAY == 0 && REPEAT_PERIOD == 0) begin : g_repeat_off
    end
`endif

    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] p;
    logic [2:0] pulse_d;
    logic [2:0] level_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    assign p = ~sync2_q;

    for (genvar i = 0; i < 3; i++) begin : g_key
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             press;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press   = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (p[i]) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!p[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        press   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!p[i]) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (p[i]) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            endcase
        end

        assign level_d[i] = (state_d == PRESSED) ||
                            (state_d == RELEASE_WAIT);

`ifdef KEY_REPEAT_EN
        logic [CNT_W-1:0] rpt_q;
        logic [CNT_W-1:0] rpt_d;
        logic             rpt_pulse;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rpt_q <= '0;
            end else begin
                rpt_q <= rpt_d;
            end
        end

        // After the first repeat the counter folds back to RPT_FIRST,
        // so it stays bounded however long the key is held.
        always_comb begin
            rpt_d     = rpt_q;
            rpt_pulse = 1'b0;
            if (state_q == PRESSED && state_d == PRESSED) begin
                rpt_d = rpt_q + CNT_ONE;
                if (rpt_d == RPT_FIRST) begin
                    rpt_pulse = 1'b1;
                end else if (rpt_d == RPT_NEXT) begin
                    rpt_pulse = 1'b1;
                    rpt_d     = RPT_FIRST;
                end
            end else if (state_d != RELEASE_WAIT) begin
                rpt_d = '0;
            end
        end

        assign pulse_d[i] = press | rpt_pulse;
`else
        assign pulse_d[i] = press;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_status <= 3'b000;
            key_level  <= 3'b000;
        end else begin
            key_status <= pulse_d;
            key_level  <= level_d;
        end
    end

endmodule
